// File: rtl/zprize_msm_pkg.sv
// Shared constants and types for the MSM limb-multiplier / column-accumulator datapath.
package zprize_msm_pkg;

    localparam int ZP_LW = 49;
    localparam int ZP_W1 = 384;
    localparam int ZP_NL = 8;
    localparam int ZP_M  = 32;
    localparam int ZP_RW = ZP_NL * ZP_LW + ZP_W1;

    // Sideband bit positions inside in_m.
    localparam int SB_FIRST   = 0;
    localparam int SB_LAST    = 1;
    localparam int SB_TAG_LSB = 2;

    typedef logic [ZP_RW-1:0] result_t;

endpackage

// File: rtl/zprize_acc_fifo2.sv
// Two-entry FIFO for finished products; push and pop may coincide even when full.
module zprize_acc_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          overflow
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic [1:0]    cnt;
    logic          pop;

    // valid/ready: the head transfers on a rising edge where valid and ready are both high;
    // head_data holds while valid is high and ready is low.
    assign valid     = (cnt != 2'd0);
    assign full      = (cnt == 2'd2);
    assign pop       = valid & ready;
    assign head_data = head_q;
    assign overflow  = push & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt    <= 2'd0;
        end else if (pop) begin
            if (push) begin
                if (cnt == 2'd2) begin
                    head_q <= tail_q;
                    tail_q <= push_data;
                end else begin
                    head_q <= push_data;
                end
            end else begin
                head_q <= tail_q;
                cnt    <= cnt - 2'd1;
            end
        end else if (push) begin
            if (cnt == 2'd0) begin
                head_q <= push_data;
                cnt    <= 2'd1;
            end else if (cnt == 2'd1) begin
                tail_q <= push_data;
                cnt    <= 2'd2;
            end
        end
    end

endmodule

// File: rtl/zprize_mul_acc_seq.sv
// Column accumulator reassembling multi-limb products from the limb multiplier stream.
// Optional protocol checking and sticky error flags: define ZPRIZE_ACC_SEQ_CHECK_EN.
module zprize_mul_acc_seq
    import zprize_msm_pkg::*;
#(
    parameter int LW = ZP_LW,
    parameter int W1 = ZP_W1,
    parameter int NL = ZP_NL,
    parameter int M  = ZP_M,
    parameter int RW = NL * LW + W1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [LW+W1-1:0] in_prod,
    input  logic [M-1:0]     in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_data,
    output logic [M-3:0]     out_tag,
    output logic [1:0]       err
);

    localparam int IW = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NL - 1);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_ACC  = 1'b1;

    logic              state;
    logic [IW-1:0]     idx;
    logic [W1:0]       acc;
    logic [NL*LW-1:0]  low;

    logic              first;
    logic              last;
    logic              in_acc;
    logic              overrun;
    logic              accept;
    logic              push;
    logic [IW-1:0]     eff_idx;
    logic [IW-1:0]     idx_inc;
    logic [W1:0]       acc_base;
    logic [LW+W1:0]    sum;
    logic [RW-1:0]     result;
    logic              fifo_ovf;
    logic              unused_full;

    // Limbs below the current position come from low; the whole sum lands at the current limb.
    function automatic logic [RW-1:0] assemble(input logic [NL*LW-1:0] lo,
                                               input logic [LW+W1-1:0] top,
                                               input logic [IW-1:0]    at);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < NL; j++) begin
            if (j < int'(at)) r[j*LW +: LW] = lo[j*LW +: LW];
        end
        r = r | (RW'(top) << (int'(at) * LW));
        return r;
    endfunction

    always_comb begin
        first    = in_m[SB_FIRST];
        last     = in_m[SB_LAST];
        in_acc   = (state == S_ACC);
        eff_idx  = first ? '0 : idx;
        acc_base = first ? '0 : acc;
        sum      = {{LW{1'b0}}, acc_base} + {1'b0, in_prod};
        idx_inc  = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        accept   = in_valid & (first | in_acc) & ~overrun;
        push     = accept & last;
        result   = assemble(low, sum[LW+W1-1:0], eff_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
            acc   <= '0;
            low   <= '0;
        end else if (accept) begin
            low[int'(eff_idx)*LW +: LW] <= sum[LW-1:0];
            acc                         <= sum[LW+W1:LW];
            if (last) begin
                state <= S_IDLE;
                idx   <= '0;
            end else begin
                state <= S_ACC;
                idx   <= first ? IW'(1) : idx_inc;
            end
        end
    end

    zprize_acc_fifo2 #(
        .DW (RW + M - 2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_m[M-1:SB_TAG_LSB], result}),
        .valid     (out_valid),
        .ready     (out_ready),
        .head_data ({out_tag, out_data}),
        .full      (unused_full),
        .overflow  (fifo_ovf)
    );

`ifdef ZPRIZE_ACC_SEQ_CHECK_EN
    logic       proto_err;
    logic [1:0] err_q;

    // A non-first, non-last limb at the final limb position has nowhere to go and is dropped.
    assign overrun   = in_acc & ~first & ~last & (idx == LAST_IDX);
    assign proto_err = in_valid & ((first & in_acc) | (~first & ~in_acc) | overrun |
                                   (push & (eff_idx != LAST_IDX)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 2'b00;
        else      err_q <= err_q | {fifo_ovf, proto_err};
    end

    assign err = err_q;
`else
    logic unused_ovf;

    assign overrun    = 1'b0;
    assign unused_ovf = fifo_ovf;
    assign err        = 2'b00;
`endif

endmodule

// File: tb/tb_zprize_mul_acc_seq.sv
// Randomized bench for zprize_mul_acc_seq against a transaction-level arithmetic model.
module tb_zprize_mul_acc_seq;
    import zprize_msm_pkg::*;

    localparam int PW = ZP_LW + ZP_W1;
    localparam int TW = ZP_M - 2;
    localparam int W  = ZP_RW + TW;
`ifdef ZPRIZE_ACC_SEQ_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [PW-1:0]   in_prod;
    logic [ZP_M-1:0] in_m;
    logic            out_valid;
    logic            out_ready;
    result_t         out_data;
    logic [TW-1:0]   out_tag;
    logic [1:0]      err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: limbs of the open transaction, FIFO contents {tag, product}, sticky errors.
    logic [W-1:0]  exp_q[$];
    logic [PW-1:0] limbs[$];
    bit            open_m;
    logic [1:0]    err_m;

    zprize_mul_acc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_m      (in_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input result_t got, input result_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic result_t golden();
        result_t s;
        s = '0;
        foreach (limbs[i]) s += result_t'(limbs[i]) << (ZP_LW * i);
        return s;
    endfunction

    function automatic logic [PW-1:0] rand_prod();
        logic [PW-1:0] p;
        p = '0;
        repeat (14) p = (p << 32) | PW'($urandom);
        return p;
    endfunction

    task automatic model_limb(input logic [PW-1:0] p, input bit f, input bit l,
                              input logic [TW-1:0] tag);
        bit take;
        take = 1'b0;
        if (f) begin
            if (open_m) err_m[0] = 1'b1;
            limbs.delete();
            limbs.push_back(p);
            open_m = 1'b1;
            take   = 1'b1;
        end else if (!open_m) begin
            err_m[0] = 1'b1;
        end else begin
            limbs.push_back(p);
            take = 1'b1;
        end
        if (take && l) begin
            if (limbs.size() != ZP_NL) err_m[0] = 1'b1;
            if (exp_q.size() < 2) exp_q.push_back({tag, golden()});
            else                  err_m[1] = 1'b1;
            open_m = 1'b0;
        end
    endtask

    // Observe the state left by the previous edge, then drive the inputs for the next edge.
    task automatic step(input bit v, input logic [PW-1:0] p, input bit f, input bit l,
                        input logic [TW-1:0] tag, input bit rdy);
        logic [W-1:0] head;
        @(negedge clk);
        check("out_valid", result_t'(out_valid), result_t'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_data", out_data, head[ZP_RW-1:0]);
            check("out_tag", result_t'(out_tag), result_t'(head[W-1:ZP_RW]));
        end
        check("err", result_t'(err), result_t'(CHECK_EN ? err_m : 2'b00));
        in_valid  = v;
        in_prod   = p;
        in_m      = {tag, l, f};
        out_ready = rdy;
        if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (v) model_limb(p, f, l, tag);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, rdy);
    endtask

    // kind: 0 random, 1 all ones value 1, 2 all-ones limb product
    task automatic send_txn(input int n, input int kind, input logic [TW-1:0] tag,
                            input int rdy_pct);
        logic [PW-1:0] p;
        for (int i = 0; i < n; i++) begin
            case (kind)
                1:       p = PW'(1);
                2:       p = '1;
                default: p = rand_prod();
            endcase
            step(1'b1, p, i == 0, i == n - 1, tag, $urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", result_t'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_tag", result_t'(out_tag), '0);
        check("rst_err", result_t'(err), '0);
        exp_q.delete();
        limbs.delete();
        open_m = 1'b0;
        err_m  = 2'b00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_m      = '0;
        out_ready = 1'b0;
        open_m    = 1'b0;
        err_m     = 2'b00;
        apply_reset();

        // Unit limbs, then all-ones limbs forcing carries across every boundary.
        send_txn(ZP_NL, 1, TW'(1), 100);
        idle(3, 1'b1);
        send_txn(ZP_NL, 2, TW'(2), 100);
        idle(3, 1'b1);

        // Back-to-back transactions with no gap.
        send_txn(ZP_NL, 0, TW'(5), 100);
        send_txn(ZP_NL, 0, TW'(6), 100);
        idle(4, 1'b1);

        // Backpressure: third result overflows the FIFO.
        send_txn(ZP_NL, 0, TW'(10), 0);
        send_txn(ZP_NL, 0, TW'(11), 0);
        send_txn(ZP_NL, 0, TW'(12), 0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Short transaction closed at limb 3, then a stray non-first limb in IDLE.
        send_txn(4, 0, TW'(20), 100);
        step(1'b1, rand_prod(), 1'b0, 1'b0, TW'(21), 1'b1);
        step(1'b1, rand_prod(), 1'b0, 1'b1, TW'(22), 1'b1);
        idle(3, 1'b1);

        // Reset with a queued result and a half-built transaction.
        send_txn(ZP_NL, 0, TW'(30), 0);
        for (int i = 0; i < 4; i++) step(1'b1, rand_prod(), i == 0, 1'b0, TW'(31), 1'b0);
        apply_reset();
        send_txn(ZP_NL, 0, TW'(32), 100);
        idle(3, 1'b1);

        // Random traffic, including abandoned transactions and gaps.
        for (int t = 0; t < 40; t++) begin
            send_txn(($urandom_range(3) == 0) ? $urandom_range(1, ZP_NL) : ZP_NL, 0,
                     TW'($urandom), 70);
            idle($urandom_range(0, 2), $urandom_range(99) < 70);
        end
        idle(6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
